shader_sequencer: RTL and testbench

- Sequences the shader execute unit: on every pixel-start strobe from VGA timing, streams the stored shader program, one instruction per cycle, with first/last markers so the execute unit can init its registers and latch the output colour.
- Holds the program memory.
- Arbitrates program writes from the configuration (SPI) side so they land only when the sequencer is idle or the frame is blanked.

---
 rtl/shader_sequencer.sv | 169 ++++++++++++++++
 tb/tb_shader_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_sequencer.sv
// rtl/shader_sequencer.sv - per-pixel shader program sequencer with write-arbitrated program memory
//
// Purpose: on each pixel_start strobe, streams the stored program to the execute
// unit one instruction per cycle, tagged with first/last markers. Configuration
// writes into the program memory are accepted only while idle or during blanking.
//
// Optional feature macro: SHADER_EARLY_HALT_EN
//   defined   - a fetched HALT_OPCODE word is presented as the last instruction
//               and the run ends there.
//   undefined - every run lasts NUM_INSTR cycles.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   pixel_start                 one-cycle strobe starting (or restarting) a run
//   frame_blank                 high during blanking; opens the write window
//   wr_req/wr_addr/wr_data      program write request, held until wr_ack
//   wr_ack                      one-cycle pulse after a write lands
//   instr/instr_valid           instruction stream to the execute unit
//   instr_first/instr_last      program boundary markers
//   busy                        sequencer in RUN
//   overrun/clear_overrun       sticky restart-while-running flag and its clear
module shader_sequencer #(
    parameter int NUM_INSTR = 16,
    parameter int INSTR_W = 8,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = {INSTR_W{1'b1}},
    localparam int PC_W = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pixel_start,
    input  logic               frame_blank,
    input  logic               wr_req,
    input  logic [PC_W-1:0]    wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    output logic               wr_ack,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic               instr_first,
    output logic               instr_last,
    output logic               busy,
    output logic               overrun,
    input  logic               clear_overrun
);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(NUM_INSTR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, pc_next;
    logic [INSTR_W-1:0] mem_q [NUM_INSTR];
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               first_q, first_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               wr_ack_q, wr_ack_d;
    logic               overrun_q, overrun_d;
    logic               wr_accept;
    logic               halt_first, halt_next;

    assign pc_next = pc_q + 1'b1;

`ifdef SHADER_EARLY_HALT_EN
    assign halt_first = (mem_q[0] == HALT_OPCODE);
    assign halt_next  = (mem_q[pc_next] == HALT_OPCODE);
`else
    logic unused_halt;
    assign halt_first  = 1'b0;
    assign halt_next   = 1'b0;
    assign unused_halt = ^HALT_OPCODE;
`endif

    // The ack register doubles as a one-cycle lockout so a held wr_req is not
    // accepted twice before the requester has seen the ack.
    assign wr_accept = wr_req && !wr_ack_q && (state_q == IDLE || frame_blank);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        first_d   = 1'b0;
        last_d    = 1'b0;
        wr_ack_d  = wr_accept;
        overrun_d = overrun_q;
        if (clear_overrun) begin
            overrun_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (pixel_start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    instr_d = mem_q[0];
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = (NUM_INSTR == 1) || halt_first;
                end
            end
            RUN: begin
                if (pixel_start) begin
                    // Restart wins over everything, even on the last cycle;
                    // setting after the clear makes set dominate.
                    overrun_d = 1'b1;
                    pc_d      = '0;
                    instr_d   = mem_q[0];
                    valid_d   = 1'b1;
                    first_d   = 1'b1;
                    last_d    = (NUM_INSTR == 1) || halt_first;
                end else if (last_q) begin
                    // instr keeps its final value while idle.
                    state_d = IDLE;
                end else begin
                    pc_d    = pc_next;
                    instr_d = mem_q[pc_next];
                    valid_d = 1'b1;
                    last_d  = (pc_next == LAST_PC) || halt_next;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_ack_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_INSTR; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            wr_ack_q  <= wr_ack_d;
            overrun_q <= overrun_d;
            // Non-blocking write: a fetch of the same word at this edge sees old data.
            if (wr_accept) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign instr_first = first_q;
    assign instr_last  = last_q;
    assign busy        = busy_q;
    assign wr_ack      = wr_ack_q;
    assign overrun     = overrun_q;
endmodule

// File: tb/tb_shader_sequencer.sv
// tb/tb_shader_sequencer.sv - self-checking bench for shader_sequencer
module tb_shader_sequencer;
    logic       clk = 1'b0;
    logic       reset, pixel_start, frame_blank, wr_req, clear_overrun;
    logic [3:0] wr_addr;
    logic [7:0] wr_data, instr;
    logic       wr_ack, instr_valid, instr_first, instr_last, busy, overrun;

    shader_sequencer dut (
        .clk(clk), .reset(reset), .pixel_start(pixel_start), .frame_blank(frame_blank),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .instr(instr), .instr_valid(instr_valid), .instr_first(instr_first),
        .instr_last(instr_last), .busy(busy), .overrun(overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] instr; logic first; logic last;} exp_t;
    typedef struct {logic [3:0] addr; logic [7:0] data; logic [7:0] exp_instr;} wr_vec_t;

    exp_t       sb[$];
    wr_vec_t    tbl[16];
    logic [7:0] mdl[16];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every valid output cycle consumes one expected record.
    always @(negedge clk) begin
        if (!reset && instr_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra: unexpected valid instr %0h at %0t", instr, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_first", instr_first, e.first);
                check("sb_last", instr_last, e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int len, input bit has_last);
        for (int i = 0; i < len; i++) begin
            sb.push_back('{mdl[i], (i == 0), (has_last && i == len - 1)});
        end
    endtask

    task automatic pulse_start();
        pixel_start = 1'b1;
        tick();
        pixel_start = 1'b0;
    endtask

    task automatic finish_run(input string name);
        repeat (16) tick();
        check({name, "_busy"}, busy, 0);
        check({name, "_valid"}, instr_valid, 0);
        check({name, "_drain"}, sb.size(), 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int t;
        t = 0;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        tick();
        while (!wr_ack && t < 40) begin
            tick();
            t++;
        end
        check("wr_ack_timeout", wr_ack, 1);
        wr_req = 1'b0;
        mdl[a] = d;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; pixel_start = 1'b0; frame_blank = 1'b0; wr_req = 1'b0;
        wr_addr = '0; wr_data = '0; clear_overrun = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mdl[i] = '0;
            tbl[i].addr = 4'(15 - i);
            tbl[i].data = 8'(8'h10 + 15 - i);
            tbl[i].exp_instr = 8'(8'h10 + 15 - i);
        end
        tick(); tick();
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_first", instr_first, 0);
        check("rst_last", instr_last, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        repeat (8) tick();

        // Zero memory run: 16 cycles, first on cycle 1, last on cycle 16.
        push_run(16, 1);
        pulse_start();
        check("t1_first", instr_first, 1);
        check("t1_busy", busy, 1);
        repeat (15) tick();
        check("t1_last", instr_last, 1);
        tick();
        check("t1_busy_end", busy, 0);
        check("t1_hold", instr, 0);
        check("t1_overrun", overrun, 0);
        check("t1_drain", sb.size(), 0);

        // Table of idle writes, each acked exactly one cycle after acceptance.
        for (int i = 0; i < 16; i++) begin
            wr_addr = tbl[i].addr;
            wr_data = tbl[i].data;
            wr_req  = 1'b1;
            tick();
            check("tbl_ack", wr_ack, 1);
            wr_req = 1'b0;
            tick();
            check("tbl_ack_drop", wr_ack, 0);
            mdl[tbl[i].addr] = tbl[i].exp_instr;
        end
        push_run(16, 1);
        pulse_start();
        finish_run("t2");

        // Write during a non-blanked run waits until the sequencer is idle.
        push_run(16, 1);
        pulse_start();
        wr_addr = 4'd3; wr_data = 8'hA5; wr_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("t3_no_ack", wr_ack, 0);
        end
        tick();
        check("t3_ack", wr_ack, 1);
        wr_req = 1'b0;
        mdl[3] = 8'hA5;
        tick();
        push_run(16, 1);
        pulse_start();
        finish_run("t3");

        // Blanked write to the word fetched at the same edge: fetch sees old data.
        push_run(16, 1);
        pulse_start();
        frame_blank = 1'b1; wr_addr = 4'd1; wr_data = 8'h5A; wr_req = 1'b1;
        tick();
        check("blank_ack", wr_ack, 1);
        wr_req = 1'b0; frame_blank = 1'b0;
        mdl[1] = 8'h5A;
        repeat (15) tick();
        check("blank_drain", sb.size(), 0);
        tick();
        push_run(16, 1);
        pulse_start();
        finish_run("blank_new");

        // Restart on the 5th run cycle.
        push_run(5, 0);
        push_run(16, 1);
        pulse_start();
        repeat (4) tick();
        pixel_start = 1'b1;
        tick();
        pixel_start = 1'b0;
        check("ovr_flag", overrun, 1);
        check("ovr_first", instr_first, 1);
        check("ovr_instr", instr, mdl[0]);
        repeat (15) tick();
        check("ovr_last", instr_last, 1);
        tick();
        check("ovr_busy", busy, 0);
        check("ovr_sticky", overrun, 1);
        check("ovr_drain", sb.size(), 0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("ovr_clear", overrun, 0);

        // Restart on the instr_last cycle, coincident with clear: set wins.
        push_run(16, 1);
        push_run(16, 1);
        pulse_start();
        repeat (15) tick();
        pixel_start = 1'b1; clear_overrun = 1'b1;
        tick();
        pixel_start = 1'b0; clear_overrun = 1'b0;
        check("lastrs_valid", instr_valid, 1);
        check("lastrs_first", instr_first, 1);
        check("lastrs_ovr", overrun, 1);
        repeat (15) tick();
        tick();
        check("lastrs_drain", sb.size(), 0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;

        // Reset at pc=7 with a write pending.
        push_run(8, 0);
        pulse_start();
        repeat (7) tick();
        wr_addr = 4'd2; wr_data = 8'h77; wr_req = 1'b1;
        #5;
        reset = 1'b1;
        #1;
        check("mid_rst_instr", instr, 0);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ack", wr_ack, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_sb", sb.size(), 0);
        tick();
        check("mid_rst_ack2", wr_ack, 0);
        wr_req = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        tick();
        push_run(16, 1);
        pulse_start();
        finish_run("post_rst");

        // Halt opcode at pc=4.
        do_write(4'd4, 8'hFF);
`ifdef SHADER_EARLY_HALT_EN
        push_run(5, 1);
`else
        push_run(16, 1);
`endif
        pulse_start();
        finish_run("halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
